// File: rtl/execute_stage_controller.sv
// Execute-stage sequencer: accepts one instruction from decode, runs the execute datapath,
// drains the result to memory and redirects fetch on taken jumps. Optional perf counters: EXEC_PERF_CNT_EN.
module execute_stage_controller #(
  parameter int XLEN         = 64,
  parameter int EXEC_TIMEOUT = 16
`ifdef EXEC_PERF_CNT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  output logic            execute_enable,
  input  logic            execute_done,
  input  logic [XLEN-1:0] alu_data_in,
  input  logic            jump_signal,
  input  logic [XLEN-1:0] jump_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_alu_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack,
  output logic            flush,
`ifdef EXEC_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_retired,
  output logic [CNT_W-1:0] perf_redirects,
  output logic            exec_timeout
`else
  output logic            exec_timeout
`endif
);

  localparam int TW = $clog2(EXEC_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(EXEC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_DRAIN    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [TW-1:0]   cnt_r;
  logic            accept_s;
  logic            capture_s;
  logic            timeout_s;
  logic            retire_s;
  logic            redirect_done_s;
  logic            enter_redirect_s;

  logic            in_ready_r;
  logic            execute_enable_r;
  logic            out_valid_r;
  logic            redirect_valid_r;
  logic            flush_r;
  logic            exec_timeout_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] alu_r;
  logic            jump_r;
  logic [XLEN-1:0] target_r;

  // Handshake events and next-state selection
  always_comb begin
    accept_s        = (state_r == S_IDLE) && in_valid && in_ready_r;
    capture_s       = (state_r == S_EXEC) && execute_done;
    timeout_s       = 1'b0;
    retire_s        = (state_r == S_DRAIN) && out_valid_r && out_ready;
    redirect_done_s = (state_r == S_REDIRECT) && redirect_valid_r && redirect_ack;
    next_state_s    = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          next_state_s = S_EXEC;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_EXEC: begin
        // done takes priority over an expiring timeout in the same cycle
        if (capture_s) begin
          next_state_s = S_DRAIN;
        end else if (cnt_r == T_LAST) begin
          timeout_s    = 1'b1;
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_EXEC;
        end
      end
      S_DRAIN: begin
        if (retire_s) begin
          next_state_s = jump_r ? S_REDIRECT : S_IDLE;
        end else begin
          next_state_s = S_DRAIN;
        end
      end
      S_REDIRECT: begin
        if (redirect_done_s) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_REDIRECT;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  assign enter_redirect_s = (next_state_s == S_REDIRECT) && (state_r != S_REDIRECT);

  // State register and control outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= S_IDLE;
      in_ready_r       <= 1'b1;
      execute_enable_r <= 1'b0;
      out_valid_r      <= 1'b0;
      redirect_valid_r <= 1'b0;
      flush_r          <= 1'b0;
    end else begin
      state_r          <= next_state_s;
      in_ready_r       <= (next_state_s == S_IDLE);
      execute_enable_r <= (next_state_s == S_EXEC);
      out_valid_r      <= (next_state_s == S_DRAIN);
      redirect_valid_r <= (next_state_s == S_REDIRECT);
      flush_r          <= enter_redirect_s;
    end
  end

  // EXEC dwell counter, restarts from zero on every EXEC entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {TW{1'b0}};
    end else if (state_r == S_EXEC) begin
      cnt_r <= cnt_r + TW'(1);
    end else begin
      cnt_r <= {TW{1'b0}};
    end
  end

  // Instruction PC and execute results held for drain and redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r     <= {XLEN{1'b0}};
      alu_r    <= {XLEN{1'b0}};
      jump_r   <= 1'b0;
      target_r <= {XLEN{1'b0}};
    end else begin
      if (accept_s) begin
        pc_r <= in_pc;
      end
      if (capture_s) begin
        alu_r    <= alu_data_in;
        jump_r   <= jump_signal;
        target_r <= jump_target;
      end
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_timeout_r <= 1'b0;
    end else begin
      exec_timeout_r <= exec_timeout_r | timeout_s;
    end
  end

`ifdef EXEC_PERF_CNT_EN
  logic [CNT_W-1:0] retired_r;
  logic [CNT_W-1:0] redirects_r;

  // Free-running retire and redirect counters, wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_r   <= {CNT_W{1'b0}};
      redirects_r <= {CNT_W{1'b0}};
    end else begin
      retired_r   <= retired_r + CNT_W'(retire_s);
      redirects_r <= redirects_r + CNT_W'(enter_redirect_s);
    end
  end

  assign perf_retired   = retired_r;
  assign perf_redirects = redirects_r;
`endif

  assign in_ready       = in_ready_r;
  assign execute_enable = execute_enable_r;
  assign out_valid      = out_valid_r;
  assign out_pc         = pc_r;
  assign out_alu_data   = alu_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = target_r;
  assign flush          = flush_r;
  assign exec_timeout   = exec_timeout_r;

endmodule

// File: tb/tb_execute_stage_controller.sv
// Randomized self-checking bench for execute_stage_controller; expectations come from
// per-instruction phase windows (EXEC d+1, DRAIN r+1, REDIRECT k+1 cycles) computed arithmetically.
module tb_execute_stage_controller;
  localparam int XLEN = 64;
  localparam int EXEC_TIMEOUT = 16;
`ifdef EXEC_PERF_CNT_EN
  localparam int CNT_W = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic [XLEN-1:0] in_pc;
  logic execute_enable;
  logic execute_done;
  logic [XLEN-1:0] alu_data_in;
  logic jump_signal;
  logic [XLEN-1:0] jump_target;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_alu_data;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic redirect_ack;
  logic flush;
  logic exec_timeout;
`ifdef EXEC_PERF_CNT_EN
  logic [CNT_W-1:0] perf_retired;
  logic [CNT_W-1:0] perf_redirects;
  int exp_ret = 0;
  int exp_red = 0;
`endif

  execute_stage_controller #(
    .XLEN(XLEN),
    .EXEC_TIMEOUT(EXEC_TIMEOUT)
`ifdef EXEC_PERF_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .execute_enable(execute_enable),
    .execute_done(execute_done),
    .alu_data_in(alu_data_in),
    .jump_signal(jump_signal),
    .jump_target(jump_target),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_alu_data(out_alu_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack),
    .flush(flush),
`ifdef EXEC_PERF_CNT_EN
    .perf_retired(perf_retired),
    .perf_redirects(perf_redirects),
`endif
    .exec_timeout(exec_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic exp_to = 1'b0;
  logic [5:0] ctrl;
  assign ctrl = {in_ready, execute_enable, out_valid, redirect_valid, flush, exec_timeout};

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // d: EXEC cycles before done, r: DRAIN stall cycles, k: REDIRECT ack delay
  task automatic run_instr(input string tag, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu,
                           input logic [XLEN-1:0] tgt, input logic jmp, input int d, input int r, input int k);
    int n_last;
    logic [5:0] exp_v;
    n_last = (d + 1) + (r + 1) + (jmp ? k + 1 : 0);
    in_valid = 1'b1; in_pc = pc; execute_done = 1'b0; out_ready = 1'b0; redirect_ack = 1'b0;
    tick();
    for (int c = 0; c <= n_last; c++) begin
      in_valid     = (c < n_last) ? 1'($urandom) : 1'b0;
      in_pc        = rnd64();
      execute_done = (c == d) ? 1'b1 : ((c > d) ? 1'($urandom) : 1'b0);
      jump_signal  = (c == d) ? jmp : 1'($urandom);
      alu_data_in  = (c == d) ? alu : rnd64();
      jump_target  = (c == d) ? tgt : rnd64();
      out_ready    = (c == d + 1 + r) ? 1'b1 : ((c <= d || c > d + 1 + r) ? 1'($urandom) : 1'b0);
      if (jmp) redirect_ack = (c <= d + 1 + r) ? 1'($urandom) : (c == d + 2 + r + k);
      else     redirect_ack = 1'($urandom);
      exp_v = {(c == n_last), (c <= d), (c >= d + 1 && c <= d + 1 + r),
               (jmp && c >= d + 2 + r && c <= d + 2 + r + k), (jmp && c == d + 2 + r), exp_to};
      n_checks++;
      if (ctrl !== exp_v) $display("FAIL %s ctrl c=%0d: got %b want %b", tag, c, ctrl, exp_v);
      else n_pass++;
      if (exp_v[3]) begin
        n_checks++;
        if ({out_pc, out_alu_data} !== {pc, alu})
          $display("FAIL %s out_data c=%0d: got %h/%h want %h/%h", tag, c, out_pc, out_alu_data, pc, alu);
        else n_pass++;
      end
      if (exp_v[2]) begin
        n_checks++;
        if (redirect_pc !== tgt) $display("FAIL %s redirect_pc c=%0d: got %h want %h", tag, c, redirect_pc, tgt);
        else n_pass++;
      end
      tick();
    end
`ifdef EXEC_PERF_CNT_EN
    exp_ret++;
    if (jmp) exp_red++;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; execute_done = 1'b0; alu_data_in = '0;
    jump_signal = 1'b0; jump_target = '0; out_ready = 1'b0; redirect_ack = 1'b0;
    #1 reset = 1'b0;
    #2;
    n_checks++;
    if (ctrl !== 6'b100000) $display("FAIL reset_ctrl: got %b want 100000", ctrl);
    else n_pass++;
    n_checks++;
    if ((out_pc | out_alu_data | redirect_pc) !== '0) $display("FAIL reset_data: got %h/%h/%h want 0", out_pc, out_alu_data, redirect_pc);
    else n_pass++;
    #4 reset = 1'b1;
    tick();
    n_checks++;
    if (ctrl !== 6'b100000) $display("FAIL reset_release: got %b want 100000", ctrl);
    else n_pass++;
  endtask

  task automatic test_alu_op();
    run_instr("alu_op", 64'h100, 64'h2A, rnd64(), 1'b0, 0, 0, 0);
  endtask

  task automatic test_branch();
    run_instr("branch", rnd64(), rnd64(), 64'h180, 1'b1, 0, 0, 3);
  endtask

  task automatic test_backpressure();
    run_instr("backpressure", rnd64(), rnd64(), rnd64(), 1'($urandom), 1, 5, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_instr("random", rnd64(), rnd64(), rnd64(), 1'($urandom), int'($urandom_range(EXEC_TIMEOUT - 1, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
  endtask

  task automatic test_done_boundary();
    run_instr("done_at_limit", rnd64(), rnd64(), rnd64(), 1'b1, EXEC_TIMEOUT - 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic j;
    logic [XLEN-1:0] pc, alu, tgt;
    logic [5:0] exp_v;
    int len;
    in_valid = 1'b1; out_ready = 1'b1; redirect_ack = 1'b1; execute_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      j = 1'($urandom); pc = rnd64(); alu = rnd64(); tgt = rnd64();
      in_pc = pc; jump_signal = 1'($urandom);
      n_checks++;
      if (ctrl !== {5'b10000, exp_to}) $display("FAIL b2b_accept i=%0d: got %b want %b", i, ctrl, {5'b10000, exp_to});
      else n_pass++;
      tick();
      len = j ? 3 : 2;
      for (int c = 0; c < len; c++) begin
        in_pc = rnd64();
        jump_signal = (c == 0) ? j : 1'($urandom);
        alu_data_in = (c == 0) ? alu : rnd64();
        jump_target = (c == 0) ? tgt : rnd64();
        exp_v = {1'b0, (c == 0), (c == 1), (j && c == 2), (j && c == 2), exp_to};
        n_checks++;
        if (ctrl !== exp_v) $display("FAIL b2b_ctrl i=%0d c=%0d: got %b want %b", i, c, ctrl, exp_v);
        else n_pass++;
        if (c == 1) begin
          n_checks++;
          if ({out_pc, out_alu_data} !== {pc, alu}) $display("FAIL b2b_out i=%0d: got %h/%h want %h/%h", i, out_pc, out_alu_data, pc, alu);
          else n_pass++;
        end
        if (j && c == 2) begin
          n_checks++;
          if (redirect_pc !== tgt) $display("FAIL b2b_redirect i=%0d: got %h want %h", i, redirect_pc, tgt);
          else n_pass++;
        end
        tick();
      end
`ifdef EXEC_PERF_CNT_EN
      exp_ret++;
      if (j) exp_red++;
`endif
    end
    in_valid = 1'b0; execute_done = 1'b0; out_ready = 1'b0; redirect_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    in_valid = 1'b1; in_pc = rnd64(); execute_done = 1'b0; out_ready = 1'b0; redirect_ack = 1'b0;
    tick();
    for (int c = 0; c < EXEC_TIMEOUT; c++) begin
      in_valid = 1'($urandom); jump_signal = 1'($urandom); out_ready = 1'($urandom);
      redirect_ack = 1'($urandom); execute_done = 1'b0;
      n_checks++;
      if (ctrl !== {5'b01000, exp_to}) $display("FAIL timeout_exec c=%0d: got %b want %b", c, ctrl, {5'b01000, exp_to});
      else n_pass++;
      tick();
    end
    exp_to = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (ctrl !== 6'b100001) $display("FAIL timeout_idle c=%0d: got %b want 100001", c, ctrl);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_sticky_timeout();
    run_instr("sticky_timeout", rnd64(), rnd64(), rnd64(), 1'($urandom), 2, 1, 1);
  endtask

  task automatic test_reset_mid();
    for (int m = 0; m < 2; m++) begin
      in_valid = 1'b1; in_pc = rnd64(); out_ready = 1'b0; redirect_ack = 1'b0; execute_done = 1'b0;
      tick();
      in_valid = 1'b0; execute_done = 1'b1; jump_signal = 1'b1; jump_target = rnd64(); alu_data_in = rnd64();
      tick();
      execute_done = 1'b0;
      if (m == 1) begin
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
      n_checks++;
      if (ctrl !== ((m == 0) ? {5'b00100, exp_to} : {5'b00011, exp_to}))
        $display("FAIL reset_mid_pre m=%0d: got %b", m, ctrl);
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      exp_to = 1'b0;
`ifdef EXEC_PERF_CNT_EN
      exp_ret = 0;
      exp_red = 0;
`endif
      n_checks++;
      if (ctrl !== 6'b100000 || (out_pc | out_alu_data | redirect_pc) !== '0)
        $display("FAIL reset_mid_async m=%0d: got %b %h %h %h want 100000 and zero data", m, ctrl, out_pc, out_alu_data, redirect_pc);
      else n_pass++;
      #3 reset = 1'b1;
      out_ready = 1'b1; redirect_ack = 1'b1; execute_done = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        n_checks++;
        if (ctrl !== 6'b100000) $display("FAIL reset_mid_after m=%0d c=%0d: got %b want 100000", m, c, ctrl);
        else n_pass++;
      end
      out_ready = 1'b0; redirect_ack = 1'b0; execute_done = 1'b0;
    end
  endtask

`ifdef EXEC_PERF_CNT_EN
  task automatic test_perf();
    n_checks++;
    if ({perf_retired, perf_redirects} !== '0) $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_retired, perf_redirects);
    else n_pass++;
    run_instr("perf", rnd64(), rnd64(), rnd64(), 1'b0, 0, 0, 0);
    run_instr("perf", rnd64(), rnd64(), rnd64(), 1'b1, 1, 0, 1);
    run_instr("perf", rnd64(), rnd64(), rnd64(), 1'b0, 2, 1, 0);
    n_checks++;
    if (perf_retired !== CNT_W'(exp_ret) || perf_redirects !== CNT_W'(exp_red))
      $display("FAIL perf_three: got %0d/%0d want %0d/%0d", perf_retired, perf_redirects, CNT_W'(exp_ret), CNT_W'(exp_red));
    else n_pass++;
    run_instr("perf", rnd64(), rnd64(), rnd64(), 1'b0, 0, 0, 0);
    run_instr("perf", rnd64(), rnd64(), rnd64(), 1'b0, 0, 0, 0);
    n_checks++;
    if (perf_retired !== CNT_W'(exp_ret) || perf_redirects !== CNT_W'(exp_red))
      $display("FAIL perf_wrap: got %0d/%0d want %0d/%0d", perf_retired, perf_redirects, CNT_W'(exp_ret), CNT_W'(exp_red));
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_alu_op();
    test_branch();
    test_backpressure();
    test_random();
    test_done_boundary();
    test_back_to_back();
    test_timeout();
    test_sticky_timeout();
    test_reset_mid();
`ifdef EXEC_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
